barrel_rotator_left_pipelined: RTL

// - Rotates a WIDTH-bit vector left by a per-transaction amount; the mirror of the right rotator.
// - Pipelined, one register stage per rotation bit, with valid/ready flow control on both sides.
// - Sits between shift/align producers and consumers on datapaths where a combinational rotator

---
 rtl/barrel_rotator_left_pipelined_pkg.sv | 14 +
 rtl/barrel_rotator_left_stage.sv | 49 ++++
 rtl/barrel_rotator_left_pipelined.sv | 59 +++++
 3 files changed

// File: rtl/barrel_rotator_left_pipelined_pkg.sv
// rtl/barrel_rotator_left_pipelined_pkg.sv - shared helpers for the pipelined left rotator
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package barrel_rotator_left_pipelined_pkg;

  // Fixed left-rotate distance applied by a stage; wraps for non-power-of-two widths.
  function automatic int unsigned stage_amount(input int unsigned width,
                                               input int unsigned stage_index);
    return (32'd1 << stage_index) % width;
  endfunction

endpackage

// File: rtl/barrel_rotator_left_stage.sv
// rtl/barrel_rotator_left_stage.sv - one pipeline stage: conditional fixed rotate plus register slice
module barrel_rotator_left_stage
  import barrel_rotator_left_pipelined_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int ROTATION_BITS = 3,
  parameter int STAGE_INDEX   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [ROTATION_BITS-1:0] in_rotation,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [ROTATION_BITS-1:0] out_rotation,
  input  logic                     out_ready
);

  localparam int unsigned AMOUNT = stage_amount(WIDTH, STAGE_INDEX);

  logic [WIDTH-1:0] rotated;

  always_comb begin
    rotated = in_data;
    if (in_rotation[STAGE_INDEX]) begin
      rotated = (in_data << AMOUNT) | (in_data >> (WIDTH - AMOUNT));
    end
  end

  // Slot is free when empty or when its occupant leaves on this same edge.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_rotation <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data     <= rotated;
        out_rotation <= in_rotation;
      end
    end
  end

endmodule

// File: rtl/barrel_rotator_left_pipelined.sv
// rtl/barrel_rotator_left_pipelined.sv - left rotator, one register stage per rotation bit
module barrel_rotator_left_pipelined
  import barrel_rotator_left_pipelined_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int WIDTH_LOG2 = `CLOG2(WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      upstream_data,
  input  logic [WIDTH_LOG2-1:0] upstream_rotation,
  input  logic                  upstream_valid,
  output logic                  upstream_ready,
  output logic [WIDTH-1:0]      downstream_data,
  output logic                  downstream_valid,
  input  logic                  downstream_ready,
  output logic                  empty
);

  // Index 0 is the upstream port; index k+1 is the output of stage k.
  logic [WIDTH_LOG2:0]                 valid_chain;
  logic [WIDTH_LOG2:0]                 ready_chain;
  logic [WIDTH_LOG2:0][WIDTH-1:0]      data_chain;
  logic [WIDTH_LOG2:0][WIDTH_LOG2-1:0] rotation_chain;
  logic                                unused_rotation;

  assign valid_chain[0]          = upstream_valid;
  assign data_chain[0]           = upstream_data;
  assign rotation_chain[0]       = upstream_rotation;
  assign ready_chain[WIDTH_LOG2] = downstream_ready;

  for (genvar k = 0; k < WIDTH_LOG2; k++) begin : g_stage
    barrel_rotator_left_stage #(
      .WIDTH        (WIDTH),
      .ROTATION_BITS(WIDTH_LOG2),
      .STAGE_INDEX  (k)
    ) u_stage (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (valid_chain[k]),
      .in_data     (data_chain[k]),
      .in_rotation (rotation_chain[k]),
      .in_ready    (ready_chain[k]),
      .out_valid   (valid_chain[k+1]),
      .out_data    (data_chain[k+1]),
      .out_rotation(rotation_chain[k+1]),
      .out_ready   (ready_chain[k+1])
    );
  end

  assign upstream_ready   = ready_chain[0];
  assign downstream_valid = valid_chain[WIDTH_LOG2];
  assign downstream_data  = data_chain[WIDTH_LOG2];
  assign empty            = ~|valid_chain[WIDTH_LOG2:1];

  // All rotation bits are consumed once the last stage has rotated.
  assign unused_rotation = ^rotation_chain[WIDTH_LOG2];

endmodule
